// File: rtl/alu_pkg.sv
// Shared ALU decode definitions: opcode/funct encodings, control-bit positions,
// occupancy states and the decoded-op packing used by the decoder and its bench.
package alu_pkg;

  localparam int CTRL_W = 12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;

  localparam logic [4:0] FN_ADD  = 5'd0;
  localparam logic [4:0] FN_COMP = 5'd1;
  localparam logic [4:0] FN_AND  = 5'd2;
  localparam logic [4:0] FN_XOR  = 5'd3;
  localparam logic [4:0] FN_DIFF = 5'd4;
  localparam logic [4:0] FN_SLLV = 5'd5;
  localparam logic [4:0] FN_SRLV = 5'd6;
  localparam logic [4:0] FN_SRAV = 5'd7;

  // Bit positions inside the one-hot control vector (LSB = add).
  localparam int CTRL_ADD      = 0;
  localparam int CTRL_MEMADD   = 1;
  localparam int CTRL_COMP     = 2;
  localparam int CTRL_SLLV     = 3;
  localparam int CTRL_SRLV     = 4;
  localparam int CTRL_SRAV     = 5;
  localparam int CTRL_AND      = 6;
  localparam int CTRL_XOR      = 7;
  localparam int CTRL_DIFF     = 8;
  localparam int CTRL_COMPEQ   = 9;
  localparam int CTRL_COMPNEQ  = 10;
  localparam int CTRL_COMPLESS = 11;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Decoded op; the decoder stores {illegal, ctrl, tag} with the tag appended.
  typedef struct packed {
    logic              illegal;
    logic [CTRL_W-1:0] ctrl;
  } dec_t;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
    return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational opcode/funct -> {illegal, one-hot ctrl} decode.
// Illegal encodings produce an all-zero control vector.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0]        i_opcode,
  input  logic [4:0]        i_funct,
  output logic              o_illegal,
  output logic [CTRL_W-1:0] o_ctrl
);

  always_comb begin
    o_illegal = 1'b0;
    o_ctrl    = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_ctrl = ctrl_bit(CTRL_ADD);
          FN_COMP: o_ctrl = ctrl_bit(CTRL_COMP);
          FN_AND:  o_ctrl = ctrl_bit(CTRL_AND);
          FN_XOR:  o_ctrl = ctrl_bit(CTRL_XOR);
          FN_DIFF: o_ctrl = ctrl_bit(CTRL_DIFF);
          FN_SLLV: o_ctrl = ctrl_bit(CTRL_SLLV);
          FN_SRLV: o_ctrl = ctrl_bit(CTRL_SRLV);
          FN_SRAV: o_ctrl = ctrl_bit(CTRL_SRAV);
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: o_ctrl = ctrl_bit(CTRL_ADD);
      OP_LW:   o_ctrl = ctrl_bit(CTRL_MEMADD);
      OP_SW:   o_ctrl = ctrl_bit(CTRL_MEMADD);
      OP_BEQ:  o_ctrl = ctrl_bit(CTRL_COMPEQ);
      OP_BNE:  o_ctrl = ctrl_bit(CTRL_COMPNEQ);
      OP_BLT:  o_ctrl = ctrl_bit(CTRL_COMPLESS);
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Registered ALU control decoder with a 2-entry skid buffer (output reg + skid reg).
// Handshake: a beat moves on a side when valid & ready are both high at the rising edge;
// out_valid and in_ready are register outputs, and the payload holds while out_valid & !out_ready.
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_funct,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        o_dbg_state
);

  localparam int ENT_W = 1 + CTRL_W + TAG_W;

  dec_t             w_dec;
  logic [ENT_W-1:0] w_in_entry;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;
  occ_e             w_state_nxt;

  occ_e             r_state;
  logic             r_in_ready;
  logic [ENT_W-1:0] r_out_entry;
  logic [ENT_W-1:0] r_skid_entry;

  alu_op_decode u_op_decode (
    .i_opcode  (in_opcode),
    .i_funct   (in_funct),
    .o_illegal (w_dec.illegal),
    .o_ctrl    (w_dec.ctrl)
  );

  assign w_in_entry = {w_dec, in_tag};
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt   = OCC_ONE;
          w_load_out_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only the output side can move.
        if (w_out_xfer) begin
          w_state_nxt     = OCC_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= OCC_EMPTY;
      r_in_ready   <= 1'b1;
      r_out_entry  <= '0;
      r_skid_entry <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != OCC_TWO);
      if (w_load_out_in) begin
        r_out_entry <= w_in_entry;
      end else if (w_load_out_skid) begin
        r_out_entry <= r_skid_entry;
      end
      if (w_load_skid) begin
        r_skid_entry <= w_in_entry;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != OCC_EMPTY);
  assign {out_illegal, out_ctrl, out_tag} = r_out_entry;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder: reset, decode table, back-pressure, streaming,
// random handshake toggling against a scoreboard, and reset while two ops are held.
module tb_alu_ctrl_decoder;
  import alu_pkg::*;

  localparam int TAG_W = 8;
  localparam int PAY_W = 1 + CTRL_W + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [4:0]        in_funct;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PAY_W-1:0] exp_q[$];

  alu_ctrl_decoder #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct    (in_funct),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_illegal (out_illegal),
    .out_tag     (out_tag),
    .o_dbg_state (o_dbg_state)
  );

  // Hand-computed decode table: {illegal, ctrl[11:0]}.
  function automatic logic [12:0] model(input logic [5:0] op, input logic [4:0] fn);
    model = 13'h1000;
    case (op)
      6'h00: begin
        case (fn)
          5'd0: model = 13'h0001;
          5'd1: model = 13'h0004;
          5'd2: model = 13'h0040;
          5'd3: model = 13'h0080;
          5'd4: model = 13'h0100;
          5'd5: model = 13'h0008;
          5'd6: model = 13'h0010;
          5'd7: model = 13'h0020;
          default: model = 13'h1000;
        endcase
      end
      6'h01: model = 13'h0001;
      6'h02: model = 13'h0002;
      6'h03: model = 13'h0002;
      6'h04: model = 13'h0200;
      6'h05: model = 13'h0400;
      6'h06: model = 13'h0800;
      default: model = 13'h1000;
    endcase
  endfunction

  logic [5:0]  dec_op  [0:6] = '{6'h00, 6'h00, 6'h03, 6'h06, 6'h07, 6'h00, 6'h01};
  logic [4:0]  dec_fn  [0:6] = '{5'd4, 5'd3, 5'd0, 5'd0, 5'd0, 5'd9, 5'd17};
  logic [12:0] dec_exp [0:6] = '{13'h0100, 13'h0080, 13'h0002, 13'h0800,
                                 13'h1000, 13'h1000, 13'h0001};

  logic [5:0]  st_op  [0:15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h3f};
  logic [4:0]  st_fn  [0:15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                 5'd8, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0};
  logic [12:0] st_exp [0:15] = '{13'h0001, 13'h0004, 13'h0040, 13'h0080,
                                 13'h0100, 13'h0008, 13'h0010, 13'h0020,
                                 13'h1000, 13'h0001, 13'h0002, 13'h0002,
                                 13'h0200, 13'h0400, 13'h0800, 13'h1000};

  // ---------------- scoreboard monitor (samples on the falling edge) ----------------
  logic             prev_stall = 1'b0;
  logic [PAY_W-1:0] prev_pay   = '0;

  always @(negedge clk) begin : mon
    logic [PAY_W-1:0] pay;
    logic [PAY_W-1:0] exp;
    pay = {out_illegal, out_ctrl, out_tag};
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || pay !== prev_pay) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%b payload=%h, required valid=1 payload=%h",
                   out_valid, pay, prev_pay);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got output %h, required no output", pay);
        end else begin
          exp = exp_q.pop_front();
          if (pay !== exp) begin
            n_fail++;
            $display("FAIL sb_order: got %h, required %h", pay, exp);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        exp_q.push_back({model(in_opcode, in_funct), in_tag});
      prev_stall = (out_valid === 1'b1 && out_ready !== 1'b1);
      prev_pay   = pay;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_opcode = 6'h00; in_funct = 5'd0;
    in_tag = 8'hAA; out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++; if (out_ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_out_ctrl: got %h, required 000", out_ctrl); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal: got %b, required 0", out_illegal); end
    n_checks++; if (out_tag !== 8'h00) begin n_fail++; $display("FAIL reset_out_tag: got %h, required 00", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_opcode = dec_op[i]; in_funct = dec_fn[i]; in_tag = 8'(8'h10 + i);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL decode_in_ready[%0d]: got %b, required 1", i, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_pre_valid[%0d]: got %b, required 0", i, out_valid); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL decode_valid[%0d]: got %b, required 1", i, out_valid); end
      n_checks++; if (out_ctrl !== dec_exp[i][11:0]) begin n_fail++; $display("FAIL decode_ctrl[%0d]: got %h, required %h", i, out_ctrl, dec_exp[i][11:0]); end
      n_checks++; if (out_illegal !== dec_exp[i][12]) begin n_fail++; $display("FAIL decode_illegal[%0d]: got %b, required %b", i, out_illegal, dec_exp[i][12]); end
      n_checks++; if (out_tag !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL decode_tag[%0d]: got %h, required %h", i, out_tag, 8'(8'h10 + i)); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 6'h00; in_funct = 5'd0; in_tag = 8'd1;
    tick();
    n_checks++; if (out_tag !== 8'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got valid=%b tag=%h, required valid=1 tag=01", out_valid, out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b, required 1", in_ready); end
    in_tag = 8'd2;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two: got %b, required 0", in_ready); end
    n_checks++; if (o_dbg_state !== 2'd2) begin n_fail++; $display("FAIL bp_state_two: got %0d, required 2", o_dbg_state); end
    in_tag = 8'd3;
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_tag !== 8'd1) begin n_fail++; $display("FAIL bp_hold: got ready=%b tag=%h, required ready=0 tag=01", in_ready, out_tag); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 8'd2) begin n_fail++; $display("FAIL bp_drain2: got valid=%b tag=%h, required valid=1 tag=02", out_valid, out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 8'd3) begin n_fail++; $display("FAIL bp_drain3: got valid=%b tag=%h, required valid=1 tag=03", out_valid, out_tag); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_opcode = st_op[i]; in_funct = st_fn[i]; in_tag = 8'(8'h20 + i);
      tick();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_flow[%0d]: got ready=%b valid=%b, required 1/1", i, in_ready, out_valid); end
      n_checks++; if ({out_illegal, out_ctrl} !== st_exp[i] || out_tag !== 8'(8'h20 + i)) begin
        n_fail++; $display("FAIL b2b_payload[%0d]: got %h/%h, required %h/%h", i, {out_illegal, out_ctrl}, out_tag, st_exp[i], 8'(8'h20 + i));
      end
      n_checks++; if ((!out_illegal && $countones(out_ctrl) != 1) || (out_illegal && out_ctrl != 12'h000)) begin
        n_fail++; $display("FAIL b2b_onehot[%0d]: got illegal=%b ctrl=%h, required one-hot or zero", i, out_illegal, out_ctrl);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b, required 0", out_valid); end
  endtask

  task automatic test_random();
    int idx;
    int budget;
    for (int c = 0; c < 10000; c++) begin
      idx = $urandom_range(0, 15);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_opcode = st_op[idx]; in_funct = st_fn[idx]; in_tag = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 8) begin
      tick();
      budget++;
    end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d ops outstanding, required 0", exp_q.size()); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %b, required 0", out_valid); end
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 6'h01; in_funct = 5'd0; in_tag = 8'd5;
    tick();
    in_tag = 8'd6;
    tick();
    n_checks++; if (o_dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst2_setup: got state %0d, required 2", o_dbg_state); end
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst2_after: got valid=%b ready=%b, required 0/1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || out_tag === 8'd5 || out_tag === 8'd6) begin
        n_fail++; $display("FAIL rst2_ghost[%0d]: got valid=%b tag=%h, required valid=0 and no tag 5/6", i, out_valid, out_tag);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct = '0; in_tag = '0;
    test_reset();
    test_decode();
    test_back_pressure();
    test_back_to_back();
    test_random();
    test_reset_in_two();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
